lab4d_sr_receiver: RTL and testbench
====================================

// Module: lab4d_sr_receiver
// PURPOSE
//  Receiving end of the LAB4D serial register-load interface (SIN/SCLK/PCLK) for one chip.
//  Deserializes the word the shift-register driver clocks out and latches it on PCLK.
//  Used as a loopback checker and register shadow next to the driver, on the same clk_i.
//  Flags malformed loads, i.e. a wrong bit count at PCLK.
// PARAMETERS
//  NBITS        24  bits per register load; word is MSB first on SIN
//  SYNC_STAGES  2   input synchronizer depth on SIN/SCLK/PCLK (>=1)
// PORTS
//  clk_i     in   1      system clock
//  rst_i     in   1      synchronous reset, active high
//  SIN       in   1      serial data from driver
//  SCLK      in   1      serial clock; SIN sampled on rising edge
//  PCLK      in   1      parallel load strobe; rising edge ends the word
//  dat_o     out  NBITS  last correctly received word
//  valid_o   out  1      1-cycle pulse: dat_o updated
//  err_o     out  1      1-cycle pulse: PCLK seen with bit count != NBITS
//  busy_o    out  1      high while a word is partially shifted in (bit count != 0)
//  addr_o    out  12     see CONFIGURATION
//  val_o     out  12     see CONFIGURATION
// BEHAVIOUR
//  - Reset: dat_o=0, valid_o=0, err_o=0, busy_o=0, addr_o=0, val_o=0.
//  - Reset also clears the shift register, the bit count, the synchronizers and the edge flops.
//  - SIN, SCLK and PCLK each pass through SYNC_STAGES flops, plus one history flop for edge detect.
//  - All three inputs have equal delay, so SIN stays aligned to SCLK.
//  - Every level on SCLK/PCLK lasting >=1 clk_i period is resolved. This covers driver prescale 0.
//  - States:
//    - IDLE: count=0.
//    - SHIFT: count>0.
//    - IDLE->SHIFT on the first SCLK rise.
//    - Any state returns to IDLE on a PCLK rise.
//  - SCLK rise: shreg <= {shreg[NBITS-2:0], SIN_sync}.
//  - Bit count: count <= count+1, 5-bit, saturating at 31.
//  - Excess bits keep shifting, so shreg holds the last NBITS bits.
//  - PCLK rise with count==NBITS: dat_o <= shreg and valid_o=1 for one cycle.
//  - PCLK rise with any other count: err_o=1 for one cycle; dat_o holds its value.
//  - A PCLK rise always clears count to 0.
//  - Latency: valid_o/err_o is high in the cycle after the (SYNC_STAGES+1)th clk_i rising edge.
//    The count starts at the first edge that samples PCLK high.
//  - SCLK and PCLK rise in the same cycle: the bit is shifted and counted first, then the PCLK check runs.
//  - PCLK rise with count=0: err_o pulses.
//  - PCLK held high: one event only, edge-triggered.
//  - busy_o = (count != 0), registered.
//  - rst_i mid-word discards the partial word with no err_o; the next word is received normally.
// CONFIGURATION
//  LAB4D_SR_RX_DECODE_EN defined:
//   - Valid only with NBITS=24; generation error otherwise.
//   - On each valid_o: addr_o <= shreg[23:12] and val_o <= shreg[11:0], same cycle as dat_o.
//  LAB4D_SR_RX_DECODE_EN undefined:
//   - addr_o and val_o are tied to 0; no decode logic.
// TESTING
//  1. Apply rst_i for 2 cycles -> dat_o=0, valid_o=0, err_o=0, busy_o=0.
//  2. Driver loopback (chip 0 lines), prescale 10, dat 24'h123456:
//     -> exactly one valid_o, dat_o=24'h123456, err_o never high.
//  3. Driver loopback, prescale 0, dat 24'hABCDEF:
//     -> one valid_o, dat_o=24'hABCDEF; busy_o falls with valid_o.
//  4. 23 SCLK pulses then PCLK -> one err_o, no valid_o, dat_o unchanged from the previous load.
//  5. 30 SCLK pulses (last 24 bits = 24'h0F0F0F) then PCLK -> err_o, dat_o unchanged, count back to 0.
//  6. rst_i after 12 bits, then a full load of 24'h000FFF -> valid_o, dat_o=24'h000FFF, no err_o.
//  7. With LAB4D_SR_RX_DECODE_EN, case 2 -> addr_o=12'h123, val_o=12'h456.
//     Without the macro, both stay 0.

Source files
------------

// File: rtl/lab4d_sr_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : lab4d_sr_receiver
//  Function : LAB4D serial register-load receiver. It deserializes SIN on SCLK
//             rises and latches the word on a PCLK rise. A PCLK rise with the
//             wrong bit count raises err_o. The optional LAB4D_SR_RX_DECODE_EN
//             macro splits each accepted word into addr_o and val_o.
//  Revision : 1.0  initial release
// ============================================================================
module lab4d_sr_receiver #(
    parameter int NBITS       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             SIN,
    input  logic             SCLK,
    input  logic             PCLK,
    output logic [NBITS-1:0] dat_o,
    output logic             valid_o,
    output logic             err_o,
    output logic             busy_o,
    output logic [11:0]      addr_o,
    output logic [11:0]      val_o
);

    localparam int          c_CNT_W     = 5;
    localparam logic [4:0]  c_CNT_MAX   = 5'd31;
    localparam logic [4:0]  c_NBITS_CNT = c_CNT_W'(NBITS);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [2:0]         r_sync [SYNC_STAGES];   // {SIN, SCLK, PCLK}
    logic [2:0]         r_hist;
    logic [NBITS-1:0]   r_shreg;
    logic [c_CNT_W-1:0] r_count;

    logic [2:0]         w_sync;
    logic               w_sin;
    logic               w_sclk_rise;
    logic               w_pclk_rise;
    logic [c_CNT_W-1:0] w_count_base;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [NBITS-1:0]   w_shreg_nxt;
    logic               w_load;

    assign w_sync      = r_sync[SYNC_STAGES-1];
    assign w_sin       = w_sync[2];
    assign w_sclk_rise = w_sync[1] & ~r_hist[1];
    assign w_pclk_rise = w_sync[0] & ~r_hist[0];

    // The bit of an SCLK rise is applied before a PCLK rise in the same cycle
    // is judged, so the PCLK check looks at the post-shift values.
    always_comb begin
        w_count_base = (r_state == ST_IDLE) ? '0 : r_count;
        w_count_nxt  = w_count_base;
        w_shreg_nxt  = r_shreg;
        if (w_sclk_rise) begin
            w_count_nxt = (w_count_base == c_CNT_MAX) ? w_count_base
                                                      : w_count_base + 5'd1;
            w_shreg_nxt = {r_shreg[NBITS-2:0], w_sin};
        end
    end

    assign w_load = w_pclk_rise && (w_count_nxt == c_NBITS_CNT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_hist  <= '0;
            r_shreg <= '0;
            r_count <= '0;
            r_state <= ST_IDLE;
            dat_o   <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            r_sync[0] <= {SIN, SCLK, PCLK};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_hist  <= w_sync;
            r_shreg <= w_shreg_nxt;
            valid_o <= 1'b0;
            err_o   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_pclk_rise) begin
                        r_count <= '0;
                        busy_o  <= 1'b0;
                        if (w_load) begin
                            dat_o   <= w_shreg_nxt;
                            valid_o <= 1'b1;
                        end else begin
                            err_o   <= 1'b1;
                        end
                    end else if (w_sclk_rise) begin
                        r_count <= w_count_nxt;
                        busy_o  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_count <= '0;
                        busy_o  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_pclk_rise) begin
                        r_count <= '0;
                        busy_o  <= 1'b0;
                        r_state <= ST_IDLE;
                        if (w_load) begin
                            dat_o   <= w_shreg_nxt;
                            valid_o <= 1'b1;
                        end else begin
                            err_o   <= 1'b1;
                        end
                    end else begin
                        r_count <= w_count_nxt;
                        busy_o  <= 1'b1;
                    end
                end
                default: begin
                    r_count <= '0;
                    busy_o  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LAB4D_SR_RX_DECODE_EN
    generate
        if (NBITS == 24) begin : g_decode
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    addr_o <= '0;
                    val_o  <= '0;
                end else if (w_load) begin
                    addr_o <= w_shreg_nxt[23:12];
                    val_o  <= w_shreg_nxt[11:0];
                end
            end
        end else begin : g_decode_bad_nbits
            $error("lab4d_sr_receiver: LAB4D_SR_RX_DECODE_EN requires NBITS == 24");
            assign addr_o = '0;
            assign val_o  = '0;
        end
    endgenerate
`else
    assign addr_o = '0;
    assign val_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lab4d_sr_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lab4d_sr_receiver
//  Function : Self-checking bench for lab4d_sr_receiver against a bit-queue
//             model of the serial load protocol.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lab4d_sr_receiver;

    localparam int NBITS = 24;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        SIN;
    logic        SCLK;
    logic        PCLK;
    logic [23:0] dat_o;
    logic        valid_o;
    logic        err_o;
    logic        busy_o;
    logic [11:0] addr_o;
    logic [11:0] val_o;

    always #5 clk_i = ~clk_i;

    lab4d_sr_receiver #(.NBITS(NBITS), .SYNC_STAGES(2)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .SIN     (SIN),
        .SCLK    (SCLK),
        .PCLK    (PCLK),
        .dat_o   (dat_o),
        .valid_o (valid_o),
        .err_o   (err_o),
        .busy_o  (busy_o),
        .addr_o  (addr_o),
        .val_o   (val_o)
    );

    int          checks    = 0;
    int          errors    = 0;
    int          valid_cnt = 0;
    int          err_cnt   = 0;
    int          exp_valid = 0;
    int          exp_err   = 0;
    logic [23:0] exp_dat   = '0;
    bit          q[$];

    always @(negedge clk_i) begin
        if (valid_o === 1'b1) valid_cnt++;
        if (err_o === 1'b1)   err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int k);
        repeat (k) @(posedge clk_i);
        #1;
    endtask

    // Reference: a load is good only if exactly NBITS bits arrived since the
    // last PCLK or reset; the word is those bits, first one most significant.
    function automatic void model_pclk();
        logic [23:0] d;
        d = '0;
        if (q.size() == NBITS) begin
            foreach (q[i]) d = {d[22:0], q[i]};
            exp_valid++;
            exp_dat = d;
        end else begin
            exp_err++;
        end
        q.delete();
    endfunction

    // mode 0: PCLK after the bits, 1: PCLK rises with the last SCLK, 2: no PCLK
    task automatic send(input logic [31:0] bits, input int n, input int pre, input int mode);
        for (int i = 0; i < n; i++) begin
            SIN  = bits[n-1-i];
            SCLK = 1'b0;
            hold(pre + 1);
            SCLK = 1'b1;
            q.push_back(bits[n-1-i]);
            if (mode == 1 && i == n - 1) PCLK = 1'b1;
            hold(pre + 1);
            SCLK = 1'b0;
        end
        if (mode == 0) begin
            hold(pre + 1);
            PCLK = 1'b1;
            hold(pre + 1);
            PCLK = 1'b0;
            model_pclk();
        end else if (mode == 1) begin
            model_pclk();
            hold(pre + 1);
            PCLK = 1'b0;
        end
    endtask

    task automatic finish_word(input string tag);
        logic [23:0] e;
        e = exp_dat;
        hold(8);
        @(negedge clk_i);
        check({tag, ":valid_count"}, valid_cnt, exp_valid);
        check({tag, ":err_count"}, err_cnt, exp_err);
        check({tag, ":dat_o"}, {8'h0, dat_o}, {8'h0, e});
        check({tag, ":busy_o"}, {31'h0, busy_o}, 32'h0);
`ifdef LAB4D_SR_RX_DECODE_EN
        check({tag, ":addr_o"}, {20'h0, addr_o}, {20'h0, e[23:12]});
        check({tag, ":val_o"}, {20'h0, val_o}, {20'h0, e[11:0]});
`else
        check({tag, ":addr_o"}, {20'h0, addr_o}, 32'h0);
        check({tag, ":val_o"}, {20'h0, val_o}, 32'h0);
`endif
    endtask

    initial begin
        logic [31:0] w;
        int          n;
        int          pre;
        int          mode;

        rst_i = 1'b1;
        SIN   = 1'b0;
        SCLK  = 1'b0;
        PCLK  = 1'b0;
        hold(2);
        @(negedge clk_i);
        check("reset:dat_o", {8'h0, dat_o}, 32'h0);
        check("reset:valid_o", {31'h0, valid_o}, 32'h0);
        check("reset:err_o", {31'h0, err_o}, 32'h0);
        check("reset:busy_o", {31'h0, busy_o}, 32'h0);
        check("reset:addr_o", {20'h0, addr_o}, 32'h0);
        check("reset:val_o", {20'h0, val_o}, 32'h0);
        rst_i = 1'b0;
        hold(2);

        send(32'h123456, 24, 10, 0);
        finish_word("load_pre10");

        // Prescale 0 with an exact-latency look at valid_o and busy_o.
        send(32'hABCDEF, 24, 0, 2);
        PCLK = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("latency:valid_early", {31'h0, valid_o}, 32'h0);
        check("latency:busy_before", {31'h0, busy_o}, 32'h1);
        @(posedge clk_i);
        @(negedge clk_i);
        check("latency:valid_on_time", {31'h0, valid_o}, 32'h1);
        check("latency:busy_falls", {31'h0, busy_o}, 32'h0);
        check("latency:dat_o", {8'h0, dat_o}, 32'hABCDEF);
        hold(6);
        PCLK = 1'b0;
        model_pclk();
        finish_word("load_pre0_held_pclk");

        send(32'h00654321, 23, 1, 0);
        finish_word("short_23");

        send({2'b10, 6'b101101, 24'h0F0F0F}, 30, 1, 0);
        finish_word("long_30");

        send(32'h0, 0, 1, 0);
        finish_word("empty_pclk");

        send(32'h00C3A5F1, 24, 0, 1);
        finish_word("same_cycle_sclk_pclk");

        send(32'h00000ABC, 12, 1, 2);
        hold(4);
        @(negedge clk_i);
        check("midword:busy_o", {31'h0, busy_o}, 32'h1);
        rst_i = 1'b1;
        hold(2);
        rst_i = 1'b0;
        q.delete();
        exp_dat = '0;
        finish_word("midword_reset");
        send(32'h000FFF, 24, 2, 0);
        finish_word("after_reset_load");

        for (int k = 0; k < 16; k++) begin
            w    = $urandom;
            n    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : 24;
            pre  = $urandom_range(0, 3);
            mode = (n == 0) ? 0 : $urandom_range(0, 1);
            send(w, n, pre, mode);
            finish_word($sformatf("random_%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
